// File: rtl/fifo_rd_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_pkg
// Shared definitions for the read-side FIFO packer.
//   FIFO_DSIZE : default FIFO entry width, matching the upstream asyn_fifo.
//   MAX_PACK   : largest supported number of lanes per packed word.
//   keep_mask  : converts a filled-lane count into a lane-valid mask.
// Lane ordering: lane 0 is the least significant lane of a packed word.
// Lane i therefore occupies bits [i*DSIZE +: DSIZE], so the oldest entry
// always ends up in the least significant bits.
// -----------------------------------------------------------------------------
package fifo_rd_packer_pkg;

    localparam int FIFO_DSIZE = 8;
    localparam int MAX_PACK   = 16;

    // Returns a mask with the low n bits set (n = 0..MAX_PACK).
    function automatic logic [MAX_PACK-1:0] keep_mask(input logic [4:0] n);
        logic [MAX_PACK:0] m;
        m = ((MAX_PACK+1)'(1) << n) - (MAX_PACK+1)'(1);
        return m[MAX_PACK-1:0];
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Pops DSIZE-wide entries from a show-ahead FIFO read port and packs PACK
// consecutive entries (lane 0 = first entry = LSB) into one output word,
// presented on a registered valid/ready interface with a per-lane keep mask.
// A flush request emits the current partial word.
//
// Ports:
//   rclk        read-domain clock
//   rrst_n      asynchronous active-low reset
//   fifo_rdata  FIFO head data (valid while fifo_empty = 0)
//   fifo_empty  FIFO empty flag
//   fifo_read   FIFO pop request (pop happens at an edge with !fifo_empty)
//   flush       single-cycle request to emit the current partial word
//   out_data    packed word, lane i = bits [i*DSIZE +: DSIZE]
//   out_keep    lane-valid mask
//   out_valid   output word valid
//   out_ready   downstream accepts the word
//   word_cnt    number of accepted words, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int PACK  = 4
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic [DSIZE-1:0]        fifo_rdata,
    input  logic                    fifo_empty,
    output logic                    fifo_read,
    input  logic                    flush,
    output logic [DSIZE*PACK-1:0]   out_data,
    output logic [PACK-1:0]         out_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             word_cnt
);

    localparam int CNT_W  = $clog2(PACK);
    localparam int ACC_W  = DSIZE * (PACK - 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK - 1);

    // The last lane is never stored: on the final pop it goes straight from
    // fifo_rdata into the output register, so acc only holds PACK-1 lanes.
    logic [ACC_W-1:0]       acc_reg;
    logic [ACC_W-1:0]       acc_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   flush_pend_reg;

    logic                   slot_free;
    logic                   pop;
    logic                   load_full;
    logic                   load_flush;
    logic                   flush_done;
    logic                   retire;
    logic [MAX_PACK-1:0]    part_mask;

    // Output register is empty or empties at this edge.
    assign slot_free = !out_valid || out_ready;

    // The last lane may only be popped when the output register can take the
    // completed word; earlier lanes just go into acc and need no slot.
    assign fifo_read = rrst_n && !fifo_empty && !flush_pend_reg &&
                       ((cnt_reg != LAST_LANE) || slot_free);

    assign pop        = fifo_read;
    assign load_full  = pop && (cnt_reg == LAST_LANE);
    assign load_flush = flush_pend_reg && (cnt_reg != '0) && slot_free;
    // A pending flush completes either immediately (nothing buffered) or when
    // the partial word is loaded.
    assign flush_done = flush_pend_reg && ((cnt_reg == '0) || slot_free);
    assign retire     = out_valid && out_ready;
    assign part_mask  = keep_mask(5'(cnt_reg));

    // Per-lane write enables for the accumulator.
    generate
        for (genvar gi = 0; gi < PACK - 1; gi++) begin : g_lane
            assign acc_next[gi*DSIZE +: DSIZE] =
                (pop && (cnt_reg == CNT_W'(gi))) ? fifo_rdata
                                                 : acc_reg[gi*DSIZE +: DSIZE];
        end
    endgenerate

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            flush_pend_reg <= 1'b0;
            out_data       <= '0;
            out_keep       <= '0;
            out_valid      <= 1'b0;
            word_cnt       <= 16'd0;
        end else begin
            // Accumulator and lane counter
            if (load_full || load_flush) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= acc_next;
                if (pop) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            // Flush request: a flush arriving while one is pending is absorbed,
            // including on the edge where the pending one completes.
            if (flush_done) begin
                flush_pend_reg <= 1'b0;
            end else if (flush) begin
                flush_pend_reg <= 1'b1;
            end

            // Output register (load_full and load_flush are mutually exclusive
            // because pops are inhibited while a flush is pending).
            if (load_full) begin
                out_data  <= {fifo_rdata, acc_reg};
                out_keep  <= '1;
                out_valid <= 1'b1;
            end else if (load_flush) begin
                out_data  <= {{DSIZE{1'b0}}, acc_reg};
                out_keep  <= part_mask[PACK-1:0];
                out_valid <= 1'b1;
            end else if (retire) begin
                out_valid <= 1'b0;
            end

            if (retire) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Directed scenarios followed by randomized traffic. A queue stands in for the
// FIFO; a lane-list reference model predicts fifo_read and the output register.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int PACK  = 4;

    logic                  rclk = 1'b0;
    logic                  rrst_n;
    logic [DSIZE-1:0]      fifo_rdata;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic                  flush;
    logic [DSIZE*PACK-1:0] out_data;
    logic [PACK-1:0]       out_keep;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           word_cnt;

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_cnt   (word_cnt)
    );

    always #5 rclk = ~rclk;

    // FIFO contents and reference model state
    logic [DSIZE-1:0] fq[$];
    logic [DSIZE-1:0] lanes[$];
    bit               m_ov;
    logic [31:0]      m_od;
    logic [3:0]       m_ok;
    bit               m_fp;
    logic [15:0]      m_wc;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lanes.delete();
        m_ov = 0; m_od = '0; m_ok = '0; m_fp = 0; m_wc = '0;
    endtask

    task automatic drive_pins();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : DSIZE'($urandom);
    endtask

    task automatic push(input logic [DSIZE-1:0] v);
        fq.push_back(v);
    endtask

    // Pack the collected lanes: first entry in the least significant byte.
    task automatic emit_word();
        logic [31:0] w;
        w = '0;
        foreach (lanes[i]) w = w | (32'(lanes[i]) << (DSIZE * i));
        m_od = w;
        m_ok = 4'((32'd1 << lanes.size()) - 1);
        m_ov = 1;
        lanes.delete();
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step(input bit ready, input bit fl);
        bit exp_read, fp_old, retire, loaded;
        out_ready = ready;
        flush     = fl;
        drive_pins();
        #1;
        exp_read = rrst_n && (fq.size() != 0) && !m_fp &&
                   ((lanes.size() != PACK - 1) || !m_ov || ready);
        chk("fifo_read", 32'(fifo_read), 32'(exp_read));
        @(posedge rclk);
        if (rrst_n) begin
            fp_old = m_fp;
            retire = m_ov && ready;
            loaded = 0;
            if (retire) m_wc++;
            if (exp_read) begin
                lanes.push_back(fq.pop_front());
                if (lanes.size() == PACK) begin
                    emit_word();
                    loaded = 1;
                end
            end else if (fp_old) begin
                if (lanes.size() == 0) begin
                    m_fp = 0;
                end else if (!m_ov || ready) begin
                    emit_word();
                    loaded = 1;
                    m_fp = 0;
                end
            end
            if (fl && !fp_old) m_fp = 1;
            if (!loaded && retire) m_ov = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_keep", 32'(out_keep), 32'(m_ok));
        end
        chk("word_cnt", 32'(word_cnt), 32'(m_wc));
        @(negedge rclk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rrst_n    = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_reset();
        drive_pins();

        // Reset state
        @(negedge rclk);
        step(1, 0);
        step(1, 0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_keep", 32'(out_keep), 32'h0);
        rrst_n = 1'b1;
        step(1, 0);

        // Continuous flow
        for (int i = 0; i < 8; i++) push(DSIZE'(2 * i));
        for (int i = 0; i < 10; i++) step(1, 0);
        chk("flow_word_cnt", 32'(word_cnt), 32'd2);

        // Backpressure: 7 pops then stall, release later
        for (int i = 0; i < 8; i++) push(DSIZE'(8'h40 + i));
        for (int i = 0; i < 10; i++) step(0, 0);
        chk("bp_fifo_left", 32'(fq.size()), 32'd1);
        chk("bp_word0", out_data, 32'h43424140);
        for (int i = 0; i < 6; i++) step(1, 0);

        // Flush partial word, then flush with nothing buffered
        push(8'h10); push(8'h12); push(8'h14);
        for (int i = 0; i < 4; i++) step(1, 0);
        step(0, 1);
        step(0, 0);
        chk("flush_data", out_data, 32'h00141210);
        chk("flush_keep", 32'(out_keep), 32'h7);
        for (int i = 0; i < 3; i++) step(1, 0);
        step(1, 1);
        for (int i = 0; i < 4; i++) step(1, 0);

        // Empty stalls between entries
        push(8'h21); push(8'h22);
        for (int i = 0; i < 20; i++) step(1, 0);
        push(8'h23); push(8'h24);
        for (int i = 0; i < 6; i++) step(1, 0);

        // Asynchronous reset after two pops of a word
        for (int i = 0; i < 4; i++) push(DSIZE'(8'h60 + i));
        step(1, 0);
        step(1, 0);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_read", 32'(fifo_read), 32'h0);
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;
        push(8'h64); push(8'h65);
        for (int i = 0; i < 7; i++) step(1, 0);
        chk("post_rst_wcnt", 32'(word_cnt), 32'h1);

        // word_cnt wrap
        force dut.word_cnt = 16'hFFFE;
        #1;
        release dut.word_cnt;
        m_wc = 16'hFFFE;
        for (int i = 0; i < 8; i++) push(DSIZE'($urandom));
        for (int i = 0; i < 12; i++) step(1, 0);
        chk("wrap", 32'(word_cnt), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (fq.size() < 16 && ($urandom % 5) < 2) push(DSIZE'($urandom));
            step(($urandom % 4) != 0, ($urandom % 16) == 0);
        end
        for (int i = 0; i < 40; i++) step(1, (i == 20));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
